// File: rtl/big_core_kbd_pkg.sv
// big_core keyboard receive path: shared types and constants.
// Scan-code constants are for downstream decode logic.
package big_core_kbd_pkg;

   localparam int KBD_DATA_BITS = 8;

   localparam logic [7:0] KBD_BREAK = 8'hF0;
   localparam logic [7:0] KBD_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } t_kbd_rx_state;

endpackage

// File: rtl/big_core_kbd_rx_if.sv
// Read-side bundle of the PS/2 receiver: FIFO pop port and status.
// The receiver is the slave; the core-side reader is the master.
interface big_core_kbd_rx_if;
   import big_core_kbd_pkg::*;

   logic                     RdEn;
   logic [KBD_DATA_BITS-1:0] RdData;
   logic                     Empty;
   logic                     Full;
   logic                     Overflow;
   logic                     FrameErr;
   logic                     Busy;

   modport master (
      output RdEn,
      input  RdData, Empty, Full,
      input  Overflow, FrameErr, Busy
   );

   modport slave (
      input  RdEn,
      output RdData, Empty, Full,
      output Overflow, FrameErr, Busy
   );

endinterface

// File: rtl/big_core_kbd_fifo.sv
// First-word-fall-through scan-code FIFO with sticky overflow.
// Storage is cleared on reset so the head reads 0 when empty.
module big_core_kbd_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             pop_ok, push_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign overflow = ovf_q;
   assign rd_data  = mem_q[rd_ptr_q];

   // a pop frees the slot the same cycle, so push is legal even when full
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (push & ~push_ok);
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: rtl/big_core_kbd_rx.sv
// PS/2 device-to-host deframer: synchronizer, falling-edge detect,
// frame FSM with abort timeout, feeding the scan-code FIFO.
module big_core_kbd_rx
   import big_core_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               KbdClockIn,
   input  logic               KbdDataIn,
   big_core_kbd_rx_if.slave   rd
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam int CW = $clog2(KBD_DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(KBD_DATA_BITS - 1);

   logic [1:0] kclk_sync_q, kclk_sync_d;
   logic       kclk_hist_q, kclk_hist_d;
   logic [1:0] kdat_sync_q, kdat_sync_d;
   logic       kbd_fall, kdat;

   t_kbd_rx_state            state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [KBD_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                     par_q, par_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic                     frame_err_q, frame_err_d;
   logic                     push;

   always_comb begin
      kclk_sync_d = {kclk_sync_q[0], KbdClockIn};
      kdat_sync_d = {kdat_sync_q[0], KbdDataIn};
      kclk_hist_d = kclk_sync_q[1];
   end

   assign kbd_fall = kclk_hist_q & ~kclk_sync_q[1];
   assign kdat     = kdat_sync_q[1];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      tmo_d       = (state_q == IDLE || kbd_fall) ? '0 : tmo_q + 1'b1;
      if (kbd_fall) begin
         unique case (state_q)
            IDLE: begin
               if (!kdat) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               shreg_d[cnt_q] = kdat;
               if (cnt_q == CNT_LAST) state_d = PARITY;
               else                   cnt_d   = cnt_q + 1'b1;
            end
            PARITY: begin
               par_d   = kdat;
               state_d = STOP;
            end
            STOP: begin
               // odd parity over data plus parity bit, stop bit high
               if (kdat && (^{shreg_q, par_q})) push        = 1'b1;
               else                             frame_err_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
         tmo_d       = '0;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         kclk_sync_q <= 2'b11;
         kclk_hist_q <= 1'b1;
         kdat_sync_q <= 2'b11;
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         kclk_sync_q <= kclk_sync_d;
         kclk_hist_q <= kclk_hist_d;
         kdat_sync_q <= kdat_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rd.Busy     = (state_q != IDLE);
   assign rd.FrameErr = frame_err_q;

   big_core_kbd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (KBD_DATA_BITS)
   ) u_fifo (
      .Clk       (Clk),
      .Rst       (Rst),
      .push      (push),
      .push_data (shreg_q),
      .pop       (rd.RdEn),
      .rd_data   (rd.RdData),
      .empty     (rd.Empty),
      .full      (rd.Full),
      .overflow  (rd.Overflow)
   );

endmodule

// File: tb/tb_big_core_kbd_rx.sv
// Directed bench for big_core_kbd_rx: PS/2 frames at a 100-cycle
// bit period, hand-computed scan codes, FIFO and error checks.
module tb_big_core_kbd_rx;

   logic Clk;
   logic Rst;
   logic KbdClockIn;
   logic KbdDataIn;

   int checks   = 0;
   int failures = 0;
   int err_total = 0;
   int base;

   big_core_kbd_rx_if bus ();

   big_core_kbd_rx #(
      .TIMEOUT_CYCLES (400),
      .FIFO_DEPTH     (4)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .KbdClockIn (KbdClockIn),
      .KbdDataIn  (KbdDataIn),
      .rd         (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (bus.FrameErr === 1'b1) err_total++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {stop, parity, data[7:0], start}
   function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                            input bit bad_par,
                                            input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   // one bit: data set while clock high, then 50 low / 50 high
   task automatic send_bit(input logic v, input bit pop);
      @(negedge Clk);
      KbdDataIn = v;
      repeat (49) @(negedge Clk);
      KbdClockIn = 1'b0;
      repeat (2) @(negedge Clk);
      bus.RdEn = pop;
      @(negedge Clk);
      bus.RdEn = 1'b0;
      repeat (47) @(negedge Clk);
      KbdClockIn = 1'b1;
   endtask

   task automatic send_seq(input logic [10:0] bits, input int n,
                           input bit pop_last);
      for (int i = 0; i < n; i++) begin
         send_bit(bits[i], pop_last && (i == n - 1));
      end
      @(negedge Clk);
      KbdDataIn = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit pop_stop);
      send_seq(mk_frame(b, bad_par, bad_stop), 11, pop_stop);
      repeat (5) @(negedge Clk);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      @(negedge Clk);
      check({tag, "_empty"}, bus.Empty, 1'b0);
      check({tag, "_data"}, bus.RdData, exp);
      bus.RdEn = 1'b1;
      @(negedge Clk);
      bus.RdEn = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b0;
      repeat (5) @(negedge Clk);
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   initial begin
      logic [10:0] fr;
      Rst        = 1'b0;
      KbdClockIn = 1'b1;
      KbdDataIn  = 1'b1;
      bus.RdEn   = 1'b0;
      repeat (4) @(negedge Clk);
      check("rst_empty", bus.Empty, 1'b1);
      check("rst_full", bus.Full, 1'b0);
      check("rst_ovf", bus.Overflow, 1'b0);
      check("rst_ferr", bus.FrameErr, 1'b0);
      check("rst_busy", bus.Busy, 1'b0);
      check("rst_rddata", bus.RdData, 8'h00);
      Rst = 1'b1;
      repeat (4) @(negedge Clk);

      // single good frame
      base = err_total;
      send_seq(mk_frame(8'h1C, 0, 0), 3, 0);
      check("t1_busy_mid", bus.Busy, 1'b1);
      send_seq(mk_frame(8'h1C, 0, 0) >> 3, 8, 0);
      repeat (5) @(negedge Clk);
      check("t1_busy_end", bus.Busy, 1'b0);
      check("t1_noerr", err_total - base, 0);
      pop_check("t1_pop", 8'h1C);
      check("t1_empty", bus.Empty, 1'b1);

      // two frames, read both in order
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h1C, 0, 0, 0);
      pop_check("t2_pop0", 8'hF0);
      pop_check("t2_pop1", 8'h1C);
      check("t2_empty", bus.Empty, 1'b1);

      // bad parity, bad stop
      base = err_total;
      send_frame(8'h1C, 1, 0, 0);
      check("t3_err_par", err_total - base, 1);
      send_frame(8'h1C, 0, 1, 0);
      check("t3_err_stop", err_total - base, 2);
      check("t3_empty", bus.Empty, 1'b1);
      check("t3_busy", bus.Busy, 1'b0);

      // partial frame then timeout
      base = err_total;
      send_seq(mk_frame(8'h1C, 0, 0), 5, 0);
      check("t4_busy_mid", bus.Busy, 1'b1);
      repeat (500) @(negedge Clk);
      check("t4_tmo_err", err_total - base, 1);
      check("t4_busy", bus.Busy, 1'b0);
      check("t4_empty", bus.Empty, 1'b1);
      send_frame(8'h1C, 0, 0, 0);
      check("t4_noerr2", err_total - base, 1);
      pop_check("t4_pop", 8'h1C);

      // overflow
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
      check("t5_full", bus.Full, 1'b1);
      check("t5_ovf", bus.Overflow, 1'b1);
      pop_check("t5_pop1", 8'h01);
      pop_check("t5_pop2", 8'h02);
      pop_check("t5_pop3", 8'h03);
      pop_check("t5_pop4", 8'h04);
      check("t5_empty", bus.Empty, 1'b1);
      check("t5_ovf_sticky", bus.Overflow, 1'b1);

      // simultaneous push and pop while full
      do_reset();
      check("t6_ovf_clr", bus.Overflow, 1'b0);
      for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0, 0, 0);
      check("t6_full", bus.Full, 1'b1);
      send_frame(8'h15, 0, 0, 1);
      check("t6_full2", bus.Full, 1'b1);
      check("t6_no_ovf", bus.Overflow, 1'b0);
      pop_check("t6_pop2", 8'h12);
      pop_check("t6_pop3", 8'h13);
      pop_check("t6_pop4", 8'h14);
      pop_check("t6_pop5", 8'h15);
      check("t6_empty", bus.Empty, 1'b1);

      // reset mid-frame; trailing bits of 0xF9 are all ones
      base = err_total;
      fr = mk_frame(8'hF9, 0, 0);
      send_seq(fr, 4, 0);
      check("t7_busy_mid", bus.Busy, 1'b1);
      do_reset();
      check("t7_busy_rst", bus.Busy, 1'b0);
      send_seq(fr >> 4, 7, 0);
      repeat (5) @(negedge Clk);
      check("t7_empty_tail", bus.Empty, 1'b1);
      send_frame(8'h2A, 0, 0, 0);
      pop_check("t7_pop", 8'h2A);
      check("t7_empty", bus.Empty, 1'b1);
      check("t7_ovf", bus.Overflow, 1'b0);
      check("t7_noerr", err_total - base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/big_core_kbd_rx.md
# big_core_kbd_rx

PS/2 keyboard receiver for the big_core keyboard path. Consumes the raw keyboard clock and data lines, which are asynchronous open-collector signals (idle high), and deframes 11-bit PS/2 device-to-host frames. It buffers the validated scan-code bytes in a small FIFO that the core (or a memory-mapped reader) pops. It sits directly downstream of the board-level keyboard pins and upstream of the core's keyboard MMIO read logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 50000 — Clk cycles without a keyboard falling edge before a partial frame is aborted (1 ms at 50 MHz).
- FIFO_DEPTH, default 4 — scan-code buffer entries; must be a power of 2, ≥2.

Ports:
- Clk  in  1  system clock (50 MHz).
- Rst  in  1  asynchronous, active-low reset.
- KbdClockIn  in  1  raw PS/2 clock from the keyboard; asynchronous.
- KbdDataIn  in  1  raw PS/2 data from the keyboard; asynchronous.
- RdEn  in  1  pop request; honoured only when Empty=0.
- RdData  out  8  FIFO head byte; valid when Empty=0 (first-word-fall-through).
- Empty  out  1  FIFO holds no bytes.
- Full  out  1  FIFO holds FIFO_DEPTH bytes.
- Overflow  out  1  sticky; a byte was dropped because the FIFO was full. Cleared only by reset.
- FrameErr  out  1  one-cycle pulse on any parity error, bad stop bit, or timeout abort.
- Busy  out  1  high while the deframer is not in IDLE.

## Operation
- Input conditioning:
  - Each line passes through a 2-flop synchronizer, then one history flop.
  - All these flops reset to 1.
  - kbd_fall = history & ~sync on the clock line.
  - Data is sampled from the synchronized data line in the cycle kbd_fall is high.
- Deframer FSM, states IDLE, DATA, PARITY, STOP. All transitions occur on kbd_fall, except timeout.
  - IDLE: sampled data 0 (start bit) → DATA, bit counter 0. Sampled data 1 → stay in IDLE, no error.
  - DATA: shift the sampled bit into bit[cnt] (LSB first). cnt==7 → PARITY, else cnt+1.
  - PARITY: store the parity bit → STOP.
  - STOP: the frame is good iff the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Good → push the byte.
    - Bad → FrameErr pulse, no push.
    - Either way → IDLE.
- Timeout:
  - The counter clears on every kbd_fall and in IDLE.
  - When not in IDLE and the counter reaches TIMEOUT_CYCLES-1 → IDLE and FrameErr pulse; the partial byte is discarded.
- FIFO:
  - Pop occurs when RdEn & ~Empty; RdEn while Empty is ignored.
  - A push while Full with no pop that cycle is dropped and sets Overflow.
  - Push and pop in the same cycle are both performed, even when Full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits.
- Reset values:
  - RdData=0x00 (storage cleared), Empty=1, Full=0, Overflow=0, FrameErr=0, Busy=0.
  - FSM in IDLE, counters 0.
- Reset asserted mid-frame discards the partial frame. After release, the receiver waits for a fresh start bit; trailing bits of the interrupted frame that sample as 1 are ignored in IDLE.

## Timing
- Keyboard clock falling at the pin → kbd_fall high 2–3 Clk cycles later, due to synchronizer latency.
- Stop-bit kbd_fall cycle → push on that Clk edge → Empty=0 and RdData valid in the next cycle.
- Pop at edge t → RdData shows the next entry (or Empty=1) in cycle t+1.
- FrameErr is exactly one Clk cycle wide: registered in the same cycle the STOP evaluation or timeout occurs.
- Busy rises in the cycle after the start-bit kbd_fall and falls in the cycle after the stop/timeout.
- PS/2 bit period (60–100 µs) far exceeds Clk, so no back-to-back kbd_fall within 3 cycles needs handling.

## Structure
- Package big_core_kbd_pkg:
  - t_kbd_rx_state enum (IDLE, DATA, PARITY, STOP).
  - KBD_DATA_BITS=8.
  - Common scan-code constants (KBD_BREAK=8'hF0, KBD_EXT=8'hE0) for downstream decode.
- Sub-module big_core_kbd_fifo: parameterised by FIFO_DEPTH and width 8, with Clk/Rst, push/pop, Empty/Full/Overflow.
- Synchronizer, edge detect, FSM and timeout counter live in big_core_kbd_rx.

## Test plan
Bench uses TIMEOUT_CYCLES=400 and a keyboard bit period of 100 Clk cycles.
- Frame 0x1C: data bits 0,0,1,1,1,0,0,0; parity 0; stop 1 → Empty falls, RdData=0x1C, FrameErr never pulses; RdEn → Empty=1.
- Frames 0xF0 (parity 1) then 0x1C back-to-back, no reads → RdData=0xF0, pop → 0x1C, pop → Empty=1.
- 0x1C with parity 1, then 0x1C with stop 0 → one FrameErr pulse each, Empty stays 1, Busy returns to 0.
- Start bit + 4 data bits, then idle 500 cycles → FrameErr pulse at the timeout, Busy=0; a following valid 0x1C is received correctly.
- 5 frames 0x01..0x05, no reads → Full=1, Overflow=1, pops return 0x01..0x04, then Empty=1; then pop and push in the same cycle while Full → count stays 4, no new Overflow event.
- Assert Rst after 3 data bits, release, send the remaining bits then a valid 0x2A → only 0x2A appears in the FIFO, Overflow=0.
